// File: rtl/spi_reg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_reg_pkg
// Description : Shared types and constants for the SPI register controller:
//               FSM state encoding, fixed register addresses and the bit
//               positions of the command and control fields.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_pkg;

    // Frame parser states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Fixed register addresses
    localparam int REG_CTRL     = 0;
    localparam int REG_ID       = 1;

    // Command byte: write/read select bit
    localparam int CMD_WR_BIT   = 7;

    // Control register: LED enable bit
    localparam int CTRL_LED_BIT = 0;

endpackage : spi_reg_pkg
`default_nettype wire

// File: rtl/spi_reg_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_reg_file
// Description : NUM_REGS x 8-bit register file with one synchronous write
//               port and one combinational read port. Address REG_ID is a
//               constant ID_VALUE; writes to it are discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_file
    import spi_reg_pkg::*;
#(
    parameter int          NUM_REGS = 8,
    parameter int          ADDR_W   = 3,
    parameter logic [7:0]  ID_VALUE = 8'h5A
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data,
    output logic              o_led
);

    logic [NUM_REGS-1:0][7:0] regs_q;
    logic [NUM_REGS-1:0][7:0] regs_d;

    // Next register contents: apply the write, then re-pin the ID entry
    always_comb begin
        regs_d = regs_q;
        if (i_wr_en) begin
            regs_d[i_wr_addr] = i_wr_data;
        end
        regs_d[REG_ID] = ID_VALUE;
    end

    // Register storage; the ID entry resets to its constant and never changes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == REG_ID) ? ID_VALUE : 8'h00;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign o_rd_data = regs_q[i_rd_addr];
    assign o_led     = regs_q[REG_CTRL][CTRL_LED_BIT];

endmodule : spi_reg_file
`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_reg_ctrl
// Description : Command/register controller behind a byte-level SPI slave.
//               Splits each CS frame into a command byte and data bytes,
//               performs auto-incrementing register reads/writes and feeds
//               the next transmit byte back to the slave.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter int          ADDR_W      = 3,
    parameter logic [7:0]  ID_VALUE    = 8'h5A,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5,
    parameter logic [7:0]  ERR_FILL    = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cs_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic       o_tx_load,
    output logic [7:0] o_tx_data,
    output logic       o_led,
    output logic       o_busy,
    output logic [7:0] o_err_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              tx_load_q, tx_load_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              w_wr_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [7:0]        w_rd_data;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [ADDR_W-1:0] w_addr_inc;
    logic              w_cmd_bad;

    assign w_cmd_addr = i_rx_data[ADDR_W-1:0];
    assign w_addr_inc = addr_q + ADDR_ONE;
    // Any set bit between the write flag and the address field is malformed
    assign w_cmd_bad  = |i_rx_data[6:ADDR_W];
    // The command byte reads its start address; later bytes read the next one
    assign w_rd_addr  = (state_q == ST_CMD) ? w_cmd_addr : w_addr_inc;

    spi_reg_file #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ID_VALUE (ID_VALUE)
    ) u_reg_file (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (addr_q),
        .i_wr_data (i_rx_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data),
        .o_led     (o_led)
    );

    // Next-state, address, TX and error-count logic; CS release overrides all
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tx_load_d = 1'b0;
        tx_data_d = tx_data_q;
        err_cnt_d = err_cnt_q;
        w_wr_en   = 1'b0;

        if (i_cs_n) begin
            state_d = ST_IDLE;
            addr_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_CMD;
                    tx_load_d = 1'b1;
                    tx_data_d = STATUS_BYTE;
                end
                ST_CMD: begin
                    if (i_rx_valid) begin
                        if (w_cmd_bad) begin
                            state_d   = ST_ERR;
                            tx_load_d = 1'b1;
                            tx_data_d = ERR_FILL;
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_d = err_cnt_q + 8'd1;
                            end
                        end else if (i_rx_data[CMD_WR_BIT]) begin
                            state_d = ST_WDATA;
                            addr_d  = w_cmd_addr;
                        end else begin
                            state_d   = ST_RDATA;
                            addr_d    = w_cmd_addr;
                            tx_load_d = 1'b1;
                            tx_data_d = w_rd_data;
                        end
                    end
                end
                ST_WDATA: begin
                    if (i_rx_valid) begin
                        w_wr_en = 1'b1;
                        addr_d  = w_addr_inc;
                    end
                end
                ST_RDATA: begin
                    if (i_rx_valid) begin
                        addr_d    = w_addr_inc;
                        tx_load_d = 1'b1;
                        tx_data_d = w_rd_data;
                    end
                end
                ST_ERR: begin
                    if (i_rx_valid) begin
                        tx_load_d = 1'b1;
                        tx_data_d = ERR_FILL;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end
            endcase
        end
    end

    // Controller state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            tx_load_q <= 1'b0;
            tx_data_q <= 8'h00;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tx_load_q <= tx_load_d;
            tx_data_q <= tx_data_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_tx_load = tx_load_q;
    assign o_tx_data = tx_data_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_err_cnt = err_cnt_q;

endmodule : spi_reg_ctrl
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_ctrl
// Description : Self-checking bench for spi_reg_ctrl. A byte-array model of
//               the register file and an error counter predict every TX
//               byte, the LED and the error count for directed and random
//               frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_ctrl;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       cs_n     = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       tx_load;
    logic [7:0] tx_data;
    logic       led;
    logic       busy;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [8];
    int         mdl_err;
    logic [7:0] last_tx;
    logic [7:0] fdat [16];

    always #5 clk = ~clk;

    spi_reg_ctrl dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_cs_n     (cs_n),
        .i_rx_valid (rx_valid),
        .i_rx_data  (rx_data),
        .o_tx_load  (tx_load),
        .o_tx_data  (tx_data),
        .o_led      (led),
        .o_busy     (busy),
        .o_err_cnt  (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mdl_rd(input int a);
        return (a == 1) ? 8'h5A : mem[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        mdl_err = 0;
        last_tx = 8'h00;
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        tick();
        last_tx = 8'hA5;
        chk("start_load", tx_load, 1);
        chk("start_data", tx_data, last_tx);
        chk("start_busy", busy, 1);
        tick();
        chk("start_load_pulse", tx_load, 0);
        repeat (4) tick();
    endtask

    // One received byte; TX response is due exactly one cycle later
    task automatic send_byte(input logic [7:0] b, input logic exp_load, input logic [7:0] exp_data);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        if (exp_load) last_tx = exp_data;
        chk("byte_load", tx_load, exp_load);
        chk("byte_data", tx_data, last_tx);
        tick();
        chk("byte_load_pulse", tx_load, 0);
        repeat (6) tick();
    endtask

    task automatic cs_end();
        cs_n = 1'b1;
        tick();
        chk("end_busy", busy, 0);
        chk("end_led", led, mem[0][0]);
        chk("end_err_cnt", err_cnt, mdl_err);
        tick();
    endtask

    // Full frame: command byte then n data bytes from fdat
    task automatic do_frame(input logic [7:0] cmd, input int n);
        int a;
        cs_start();
        if (cmd[6:3] != 4'd0) begin
            if (mdl_err < 255) mdl_err++;
            send_byte(cmd, 1'b1, 8'hFF);
            for (int i = 0; i < n; i++) send_byte(fdat[i], 1'b1, 8'hFF);
        end else if (cmd[7]) begin
            a = int'(cmd[2:0]);
            send_byte(cmd, 1'b0, 8'h00);
            for (int i = 0; i < n; i++) begin
                if (a != 1) mem[a] = fdat[i];
                a = (a + 1) % 8;
                send_byte(fdat[i], 1'b0, 8'h00);
            end
        end else begin
            a = int'(cmd[2:0]);
            send_byte(cmd, 1'b1, mdl_rd(a));
            for (int i = 0; i < n; i++) begin
                a = (a + 1) % 8;
                send_byte(fdat[i], 1'b1, mdl_rd(a));
            end
        end
        cs_end();
    endtask

    task automatic read_all();
        for (int i = 0; i < 7; i++) fdat[i] = 8'($urandom);
        do_frame(8'h00, 7);
    endtask

    initial begin
        logic [7:0] cmd;
        int         n;

        mdl_reset();
        repeat (3) tick();
        chk("rst_load", tx_load, 0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_cnt, 0);
        rst_n = 1'b1;
        tick();
        read_all();

        // Write frame then read back
        fdat[0] = 8'hAA; fdat[1] = 8'h3C;
        do_frame(8'h80, 2);
        fdat[0] = 8'h01; fdat[1] = 8'h02; fdat[2] = 8'h03;
        do_frame(8'h00, 3);

        // Address wrap, then LED on
        fdat[0] = 8'h11; fdat[1] = 8'h22;
        do_frame(8'h87, 2);
        fdat[0] = 8'h01;
        do_frame(8'h80, 1);
        chk("led_on", led, 1);

        // Malformed command, then saturation
        fdat[0] = 8'h99;
        do_frame(8'h48, 1);
        for (int k = 0; k < 300; k++) begin
            cmd = 8'($urandom);
            if (cmd[6:3] == 4'd0) cmd[3] = 1'b1;
            do_frame(cmd, 0);
        end
        chk("err_saturated", err_cnt, 255);
        read_all();

        // Random frames
        for (int k = 0; k < 25; k++) begin
            cmd = 8'($urandom);
            if ($urandom_range(0, 3) != 0) cmd[6:3] = 4'd0;
            n = $urandom_range(0, 9);
            for (int i = 0; i < n; i++) fdat[i] = 8'($urandom);
            do_frame(cmd, n);
        end
        read_all();

        // CS abort coinciding with a data byte
        fdat[0] = 8'hC3;
        do_frame(8'h83, 1);
        cs_start();
        send_byte(8'h83, 1'b0, 8'h00);
        cs_n     = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        tick();
        rx_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_load", tx_load, 0);
        tick();
        do_frame(8'h03, 0);

        // Asynchronous reset in the middle of a write frame
        fdat[0] = 8'h01;
        do_frame(8'h80, 1);
        cs_start();
        send_byte(8'h80, 1'b0, 8'h00);
        send_byte(8'h55, 1'b0, 8'h00);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        mdl_reset();
        chk("arst_load", tx_load, 0);
        chk("arst_data", tx_data, 8'h00);
        chk("arst_led", led, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", err_cnt, 0);
        cs_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        read_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spi_reg_ctrl
`default_nettype wire
